// File: rtl/sos_sequencer_if.sv
// Symbol/status bundle between the SOS letter sequencer and its environment.
// master drives enable and symbol pulses; slave is the sequencer itself.
interface sos_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             en;
  logic             dot_is;
  logic             dash_is;
  logic             sos_found;
  logic             err;
  logic             tmo;
  logic [1:0]       state;
  logic [CNT_W-1:0] sym_cnt;

  modport master (
    output en, dot_is, dash_is,
    input  sos_found, err, tmo, state, sym_cnt
  );

  modport slave (
    input  en, dot_is, dash_is,
    output sos_found, err, tmo, state, sym_cnt
  );
endinterface

// File: rtl/sos_sequencer.sv
// Letter-level S-O-S sequencer driven by dot/dash pulses, with inter-symbol timeout.
// Optional macro SOS_OVERLAP_EN: the closing S of one SOS also opens the next one.
module sos_sequencer #(
  parameter int N_DOT   = 3,
  parameter int N_DASH  = 3,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 4,
  parameter int TMO_W   = 6
) (
  input logic                  clk,
  input logic                  rst,
  sos_sequencer_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_O    = 2'd2,
    ST_S2   = 2'd3
  } state_t;

  // A dot that opens a new S lands directly in O when one dot already makes an S.
  localparam state_t           START_ST  = (N_DOT == 1) ? ST_O : ST_S1;
  localparam logic [CNT_W-1:0] START_CNT = (N_DOT == 1) ? '0 : CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(N_DOT - 1);
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(N_DASH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

`ifdef SOS_OVERLAP_EN
  localparam state_t AFTER_FOUND = ST_O;
`else
  localparam state_t AFTER_FOUND = ST_IDLE;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;

  logic dot, dash;
  assign dot  = bus.dot_is;
  assign dash = bus.dash_is;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tmo_cnt_q <= '0;
      found_q   <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      found_q   <= found_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    found_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = 1'b0;

    if (!bus.en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      tmo_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
      if (dot && !dash) begin
        state_d = START_ST;
        cnt_d   = START_CNT;
      end
    end else if (dot && dash) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      tmo_cnt_d = '0;
      err_d     = 1'b1;
    end else if (dot || dash) begin
      // Any symbol inside a pattern restarts the inter-symbol timer, even on its expiry cycle.
      tmo_cnt_d = '0;
      case (state_q)
        ST_S1: begin
          if (dot) begin
            if (cnt_q == DOT_LAST) begin
              state_d = ST_O;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
        ST_O: begin
          if (dash) begin
            if (cnt_q == DASH_LAST) begin
              state_d = ST_S2;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = START_ST;
            cnt_d   = START_CNT;
          end
        end
        ST_S2: begin
          if (dot) begin
            if (cnt_q == DOT_LAST) begin
              state_d = AFTER_FOUND;
              cnt_d   = '0;
              found_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else if (tmo_cnt_q == TMO_LAST) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      tmo_cnt_d = '0;
      err_d     = 1'b1;
      tmo_d     = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign bus.sos_found = found_q;
  assign bus.err       = err_q;
  assign bus.tmo       = tmo_q;
  assign bus.state     = state_q;
  assign bus.sym_cnt   = cnt_q;

endmodule

// File: tb/tb_sos_sequencer.sv
// Directed self-checking bench for sos_sequencer (N_DOT=N_DASH=3, TIMEOUT=32).
// Honours SOS_OVERLAP_EN for the state expected after a completed SOS.
module tb_sos_sequencer;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  sos_sequencer_if #(.CNT_W(4)) bus ();

  sos_sequencer #(
    .N_DOT(3), .N_DASH(3), .TIMEOUT(32), .CNT_W(4), .TMO_W(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SOS_OVERLAP_EN
  localparam logic [1:0] AFTER_FOUND = 2'd2;
`else
  localparam logic [1:0] AFTER_FOUND = 2'd0;
`endif

  // Advance one clock and settle just after the edge so outputs are stable.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic d, input logic s);
    bus.dot_is  = d;
    bus.dash_is = s;
    tick(1);
    bus.dot_is  = 1'b0;
    bus.dash_is = 1'b0;
  endtask

  task automatic go_idle();
    bus.en = 1'b0;
    tick(1);
    bus.en = 1'b1;
  endtask

  task automatic test_reset();
    bus.en      = 1'b1;
    bus.dot_is  = 1'b0;
    bus.dash_is = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    compared++;
    if (bus.state !== 2'd0 || bus.sym_cnt !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: state=%0d cnt=%0d required state=0 cnt=0", bus.state, bus.sym_cnt);
    end
    compared++;
    if ({bus.sos_found, bus.err, bus.tmo} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_pulses: found/err/tmo=%b required 000", {bus.sos_found, bus.err, bus.tmo});
    end
  endtask

  task automatic run_sos(input int gap, input string name);
    logic [1:0] exp_state [9];
    logic [3:0] exp_cnt   [9];
    exp_state = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, AFTER_FOUND};
    exp_cnt   = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
    for (int i = 0; i < 9; i++) begin
      if (i >= 3 && i < 6) applyStimulus(1'b0, 1'b1);
      else                 applyStimulus(1'b1, 1'b0);
      compared++;
      if (bus.state !== exp_state[i] || bus.sym_cnt !== exp_cnt[i] ||
          bus.sos_found !== (i == 8) || bus.err !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL %s_pulse%0d: state=%0d cnt=%0d found=%b err=%b required state=%0d cnt=%0d found=%b err=0",
                 name, i + 1, bus.state, bus.sym_cnt, bus.sos_found, bus.err,
                 exp_state[i], exp_cnt[i], (i == 8));
      end
      if (i < 8) tick(gap);
    end
    tick(1);
    compared++;
    if (bus.sos_found !== 1'b0 || bus.state !== AFTER_FOUND) begin
      mismatched++;
      $display("[TB] FAIL %s_found_width: found=%b state=%0d required found=0 state=%0d",
               name, bus.sos_found, bus.state, AFTER_FOUND);
    end
  endtask

  task automatic test_sos();
    go_idle();
    run_sos(3, "sos");
  endtask

  task automatic test_back_to_back();
    go_idle();
    run_sos(0, "b2b");
  endtask

  task automatic test_bad_dash();
    go_idle();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    compared++;
    if (bus.err !== 1'b1 || bus.tmo !== 1'b0 || bus.state !== 2'd0 || bus.sym_cnt !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL dash_in_s1: err=%b tmo=%b state=%0d cnt=%0d required err=1 tmo=0 state=0 cnt=0",
               bus.err, bus.tmo, bus.state, bus.sym_cnt);
    end
    tick(1);
    compared++;
    if (bus.err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL dash_err_width: err=%b required 0", bus.err);
    end
    applyStimulus(1'b0, 1'b1);
    compared++;
    if (bus.err !== 1'b0 || bus.state !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL dash_in_idle: err=%b state=%0d required err=0 state=0", bus.err, bus.state);
    end
  endtask

  task automatic test_timeout();
    go_idle();
    applyStimulus(1'b1, 1'b0);
    tick(31);
    compared++;
    if (bus.err !== 1'b0 || bus.state !== 2'd1 || bus.sym_cnt !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL tmo_early: err=%b state=%0d cnt=%0d required err=0 state=1 cnt=1",
               bus.err, bus.state, bus.sym_cnt);
    end
    tick(1);
    compared++;
    if (bus.err !== 1'b1 || bus.tmo !== 1'b1 || bus.state !== 2'd0 || bus.sym_cnt !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL tmo_expiry: err=%b tmo=%b state=%0d cnt=%0d required err=1 tmo=1 state=0 cnt=0",
               bus.err, bus.tmo, bus.state, bus.sym_cnt);
    end
    tick(1);
    compared++;
    if (bus.err !== 1'b0 || bus.tmo !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL tmo_width: err=%b tmo=%b required 0 0", bus.err, bus.tmo);
    end
    applyStimulus(1'b1, 1'b0);
    tick(31);
    applyStimulus(1'b1, 1'b0);
    compared++;
    if (bus.err !== 1'b0 || bus.tmo !== 1'b0 || bus.state !== 2'd1 || bus.sym_cnt !== 4'd2) begin
      mismatched++;
      $display("[TB] FAIL tmo_symbol_wins: err=%b tmo=%b state=%0d cnt=%0d required err=0 tmo=0 state=1 cnt=2",
               bus.err, bus.tmo, bus.state, bus.sym_cnt);
    end
    tick(31);
    compared++;
    if (bus.err !== 1'b0 || bus.state !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL tmo_restart: err=%b state=%0d required err=0 state=1", bus.err, bus.state);
    end
  endtask

  task automatic test_resync_collision();
    go_idle();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    compared++;
    if (bus.state !== 2'd1 || bus.sym_cnt !== 4'd1 || bus.err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL resync: state=%0d cnt=%0d err=%b required state=1 cnt=1 err=0",
               bus.state, bus.sym_cnt, bus.err);
    end
    applyStimulus(1'b1, 1'b1);
    compared++;
    if (bus.err !== 1'b1 || bus.tmo !== 1'b0 || bus.state !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL collide_s1: err=%b tmo=%b state=%0d required err=1 tmo=0 state=0",
               bus.err, bus.tmo, bus.state);
    end
    applyStimulus(1'b1, 1'b1);
    compared++;
    if (bus.err !== 1'b0 || bus.state !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL collide_idle: err=%b state=%0d required err=0 state=0", bus.err, bus.state);
    end
  endtask

  task automatic test_reset_and_enable();
    go_idle();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    compared++;
    if (bus.state !== 2'd2 || bus.sym_cnt !== 4'd2) begin
      mismatched++;
      $display("[TB] FAIL pre_reset: state=%0d cnt=%0d required state=2 cnt=2", bus.state, bus.sym_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (bus.state !== 2'd0 || bus.sym_cnt !== 4'd0 || {bus.sos_found, bus.err, bus.tmo} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL async_reset: state=%0d cnt=%0d pulses=%b required 0 0 000",
               bus.state, bus.sym_cnt, {bus.sos_found, bus.err, bus.tmo});
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) applyStimulus(i >= 3 && i < 6 ? 1'b0 : 1'b1, i >= 3 && i < 6 ? 1'b1 : 1'b0);
    bus.en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    compared++;
    if (bus.sos_found !== 1'b0 || bus.state !== 2'd0 || bus.sym_cnt !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL en_suppress: found=%b state=%0d cnt=%0d required found=0 state=0 cnt=0",
               bus.sos_found, bus.state, bus.sym_cnt);
    end
    bus.en = 1'b1;
    tick(1);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.dot_is  = 1'b0;
    bus.dash_is = 1'b0;
    test_reset();
    test_sos();
    test_back_to_back();
    test_bad_dash();
    test_timeout();
    test_resync_collision();
    test_reset_and_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
